// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding-select, stall, flush and freeze control for the
//               5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_access,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             stage_en,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic             r_ex_valid, r_ex_use_rs, r_ex_use_rt;
  logic             r_ex_reg_write, r_ex_mem_read, r_ex_mem_access;
  logic [REG_W-1:0] r_ex_rs, r_ex_rt, r_ex_dest;
  logic             r_mem_valid, r_mem_reg_write, r_mem_mem_access;
  logic [REG_W-1:0] r_mem_dest;
  logic             r_wb_valid, r_wb_reg_write;
  logic [REG_W-1:0] r_wb_dest;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_freeze;
  logic w_load_use;

  assign w_freeze   = r_mem_valid & r_mem_mem_access & ~dmem_ready;
  assign w_load_use = id_valid & r_ex_valid & r_ex_mem_read & (r_ex_dest != '0) &
                      ((id_use_rs & (id_rs == r_ex_dest)) |
                       (id_use_rt & (id_rt == r_ex_dest)));

  // Priority: freeze > taken branch > load-use > normal flow.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stage_en   = 1'b1;
    if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      stage_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // MEM holds the newer value, so it wins over WB; r0 is hardwired zero.
  always_comb begin
    fwd_a_sel = 2'b00;
    if (r_ex_valid && r_ex_use_rs && (r_ex_rs != '0)) begin
      if (r_mem_valid && r_mem_reg_write && (r_mem_dest == r_ex_rs))
        fwd_a_sel = 2'b10;
      else if (r_wb_valid && r_wb_reg_write && (r_wb_dest == r_ex_rs))
        fwd_a_sel = 2'b01;
    end
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if (r_ex_valid && r_ex_use_rt && (r_ex_rt != '0)) begin
      if (r_mem_valid && r_mem_reg_write && (r_mem_dest == r_ex_rt))
        fwd_b_sel = 2'b10;
      else if (r_wb_valid && r_wb_reg_write && (r_wb_dest == r_ex_rt))
        fwd_b_sel = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid       <= 1'b0;
      r_ex_use_rs      <= 1'b0;
      r_ex_use_rt      <= 1'b0;
      r_ex_reg_write   <= 1'b0;
      r_ex_mem_read    <= 1'b0;
      r_ex_mem_access  <= 1'b0;
      r_ex_rs          <= '0;
      r_ex_rt          <= '0;
      r_ex_dest        <= '0;
      r_mem_valid      <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_access <= 1'b0;
      r_mem_dest       <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_reg_write   <= 1'b0;
      r_wb_dest        <= '0;
      r_stall_cycles   <= '0;
    end else begin
      if (stage_en) begin
        r_wb_valid       <= r_mem_valid;
        r_wb_reg_write   <= r_mem_reg_write;
        r_wb_dest        <= r_mem_dest;
        r_mem_valid      <= r_ex_valid;
        r_mem_reg_write  <= r_ex_reg_write;
        r_mem_mem_access <= r_ex_mem_access;
        r_mem_dest       <= r_ex_dest;
        r_ex_valid       <= id_valid & ~idex_flush;
        r_ex_use_rs      <= id_use_rs;
        r_ex_use_rt      <= id_use_rt;
        r_ex_reg_write   <= id_reg_write;
        r_ex_mem_read    <= id_mem_read;
        r_ex_mem_access  <= id_mem_access;
        r_ex_rs          <= id_rs;
        r_ex_rt          <= id_rt;
        r_ex_dest        <= id_dest;
      end
      if (!pc_en && (r_stall_cycles != c_CNT_MAX))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed-vector scoreboard bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // {pc_en, ifid_en, ifid_flush, idex_flush, stage_en}
  localparam logic [4:0] c_NORM = 5'b11001;
  localparam logic [4:0] c_LU   = 5'b00011;
  localparam logic [4:0] c_BR   = 5'b11111;
  localparam logic [4:0] c_FRZ  = 5'b00000;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs, id_use_rt;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic             id_reg_write, id_mem_read, id_mem_access;
  logic             ex_branch_taken, dmem_ready;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, stage_en;
  logic [CNT_W-1:0] stall_cycles;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_access(id_mem_access), .ex_branch_taken(ex_branch_taken),
    .dmem_ready(dmem_ready), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stage_en(stage_en), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [4:0]       ctl;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  // Pending ID-stage instruction, applied on the next cycle.
  logic             n_v, n_urs, n_urt, n_rw, n_mr, n_ma;
  logic [REG_W-1:0] n_rs, n_rt, n_dest;

  task automatic set_id(input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input int dest,
                        input logic rw, input logic mr, input logic ma);
    n_v = v; n_rs = REG_W'(rs); n_rt = REG_W'(rt); n_urs = urs; n_urt = urt;
    n_dest = REG_W'(dest); n_rw = rw; n_mr = mr; n_ma = ma;
  endtask

  task automatic set_nop();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc(input string name, input bit chk, input logic r,
                     input logic br, input logic rdy, input logic [1:0] fa,
                     input logic [1:0] fb, input logic [4:0] ctl, input int stall);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_branch_taken = br; dmem_ready = rdy;
    id_valid = n_v; id_rs = n_rs; id_rt = n_rt; id_use_rs = n_urs;
    id_use_rt = n_urt; id_dest = n_dest; id_reg_write = n_rw;
    id_mem_read = n_mr; id_mem_access = n_ma;
    if (chk) begin
      e.name = name; e.fa = fa; e.fb = fb; e.ctl = ctl; e.stall = CNT_W'(stall);
      q.push_back(e);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act, req;
      e = q.pop_front();
      act = {fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_flush, stage_en};
      req = {e.fa, e.fb, e.ctl};
      n_vec++;
      if (act !== req || stall_cycles !== e.stall) begin
        n_fail++;
        $display("FAIL %s: got fa/fb/pc/ifen/iff/idf/sen=%b stall=%0d, expected %b stall=%0d",
                 e.name, act, stall_cycles, req, e.stall);
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      n_fail++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "timeout");
    end
  end

  initial begin
    logic rbr;
    rst = 1'b1; ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_access = 1'b0;
    set_nop();

    // Reset with random inputs; records are cleared, branch input still flushes.
    set_id(1'($urandom), $urandom_range(31), $urandom_range(31), 1'($urandom),
           1'($urandom), $urandom_range(31), 1'($urandom), 1'($urandom), 1'($urandom));
    cyc("rst0", 0, 1, 1'($urandom), 1'($urandom), 2'b00, 2'b00, c_NORM, 0);
    rbr = 1'($urandom);
    cyc("rst1", 1, 1, rbr, 1'($urandom), 2'b00, 2'b00, rbr ? c_BR : c_NORM, 0);
    set_nop();
    cyc("after_rst", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);

    // add r3 ; sub r5,r3,r4 back to back -> MEM forward on A
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc("add_r3", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 0); cyc("sub_id", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_nop();                          cyc("fwd_mem", 1, 0, 0, 1, 2'b10, 2'b00, c_NORM, 0);

    // one instruction between -> WB forward on A
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc("add_r3_b", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 8, 9, 1, 1, 7, 1, 0, 0); cyc("or_r7", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 0); cyc("sub_id_b", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_nop();                          cyc("fwd_wb", 1, 0, 0, 1, 2'b01, 2'b00, c_NORM, 0);

    // MEM and WB both write r3 -> MEM wins
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc("add_r3_c", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc("add_r3_d", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 0); cyc("sub_id_c", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_nop();                          cyc("fwd_prio", 1, 0, 0, 1, 2'b10, 2'b00, c_NORM, 0);

    // lw r2 ; add r6,r2,r2 -> one stall cycle then WB forward on both
    set_id(1, 1, 0, 1, 0, 2, 1, 1, 1); cyc("lw_r2", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 0);
    set_id(1, 2, 2, 1, 1, 6, 1, 0, 0); cyc("lu_stall", 1, 0, 0, 1, 2'b00, 2'b00, c_LU, 0);
    cyc("lu_release", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_nop();                          cyc("lu_fwd_wb", 1, 0, 0, 1, 2'b01, 2'b01, c_NORM, 1);

    // lw r0 ; use of r0 -> no stall, no forwarding
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 1); cyc("lw_r0", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_id(1, 0, 0, 1, 1, 8, 1, 0, 0); cyc("r0_nostall", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_nop();                          cyc("r0_nofwd", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);

    // taken branch concurrent with load-use -> branch flush, no stall count
    set_id(1, 1, 0, 1, 0, 2, 1, 1, 1); cyc("lw_r2_b", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_id(1, 2, 2, 1, 1, 6, 1, 0, 0); cyc("br_over_lu", 1, 0, 1, 1, 2'b00, 2'b00, c_BR, 1);
    set_nop();                          cyc("br_after", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);

    // sw in MEM waits 3 cycles, branch during wait is ignored
    set_id(1, 1, 5, 1, 1, 0, 0, 0, 1);   cyc("sw_id", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_id(1, 10, 11, 1, 1, 9, 1, 0, 0); cyc("add_r9", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 1);
    set_id(1, 13, 14, 1, 1, 12, 1, 0, 0);
    cyc("frz1", 1, 0, 0, 0, 2'b00, 2'b00, c_FRZ, 1);
    cyc("frz2_br", 1, 0, 1, 0, 2'b00, 2'b00, c_FRZ, 2);
    cyc("frz3", 1, 0, 0, 0, 2'b00, 2'b00, c_FRZ, 3);
    cyc("frz_done", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 4);
    set_nop();                           cyc("post_frz", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 4);

    // reset during the second wait cycle ends the freeze
    set_id(1, 1, 5, 1, 1, 0, 0, 0, 1); cyc("sw_id_b", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 4);
    set_nop();                          cyc("sw_ex_b", 1, 0, 0, 1, 2'b00, 2'b00, c_NORM, 4);
    cyc("frz_b1", 1, 0, 0, 0, 2'b00, 2'b00, c_FRZ, 4);
    cyc("frz_b2_rst", 1, 1, 0, 0, 2'b00, 2'b00, c_FRZ, 5);
    cyc("rst_unfrz", 1, 0, 0, 0, 2'b00, 2'b00, c_NORM, 0);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
